prgrm_cnt_stack: RTL and testbench

Program counter and hardware return-address stack, fed directly by the program decode stage. It consumes the decode stage's `Incrmnt_PC`, `Ld_Brnch_Addr` and `Ld_Rtn_Addr` strobes together with the current instruction's call bit and target field. It produces the registered fetch address `PC`. Calls push the return address (`PC+1`) onto an on-chip LIFO; returns pop it.

---
 rtl/prgrm_cnt_stack_if.sv | 29 ++
 rtl/prgrm_cnt_stack.sv | 128 ++++++++++++
 tb/tb_prgrm_cnt_stack.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prgrm_cnt_stack_if.sv
// prgrm_cnt_stack_if: decode-stage to program-counter bus.
// The decode stage (master) drives the action strobes, the call bit, the
// branch target and the error-clear; the PC/stack block (slave) returns the
// fetch address and the stack status flags.
interface prgrm_cnt_stack_if #(
    parameter int ADDR_W = 8
);
    logic              Incrmnt_PC;
    logic              Ld_Brnch_Addr;
    logic              Ld_Rtn_Addr;
    logic              Call_Instrn;
    logic [ADDR_W-1:0] Brnch_Addr;
    logic              Err_Clr;
    logic [ADDR_W-1:0] PC;
    logic              Stack_Empty;
    logic              Stack_Full;
    logic              Stack_Ovf;
    logic              Stack_Unf;

    modport master (
        output Incrmnt_PC, Ld_Brnch_Addr, Ld_Rtn_Addr, Call_Instrn, Brnch_Addr, Err_Clr,
        input  PC, Stack_Empty, Stack_Full, Stack_Ovf, Stack_Unf
    );

    modport slave (
        input  Incrmnt_PC, Ld_Brnch_Addr, Ld_Rtn_Addr, Call_Instrn, Brnch_Addr, Err_Clr,
        output PC, Stack_Empty, Stack_Full, Stack_Ovf, Stack_Unf
    );
endinterface

// File: rtl/prgrm_cnt_stack.sv
// prgrm_cnt_stack: program counter with a hardware return-address stack.
// One action per cycle in priority order RETURN > BRANCH(/CALL) > INCR > HOLD.
// A call pushes PC+1; a return pops the top entry into PC. All outputs are
// flops, so there is no combinational input-to-output path.
// Optional feature: define PC_STACK_OVF_WRAP_EN to make a push while full
// overwrite the oldest entry; by default such a push is dropped. Both modes
// set the sticky Stack_Ovf flag.
module prgrm_cnt_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_ADDR  = 0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    prgrm_cnt_stack_if.slave      bus
);
    localparam int PTR_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0]  RST_PC     = ADDR_W'(RESET_ADDR);
    localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] ZERO_DEPTH = {DEPTH_W{1'b0}};

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [ADDR_W-1:0]  stack_mem_q [STACK_DEPTH];

    logic [ADDR_W-1:0]  pc_inc_s;
    logic               wr_en_s;

    assign pc_inc_s = pc_q + ADDR_W'(1);

    // Next-state selection: pick the single highest-priority action.
    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        depth_d = depth_q;
        wr_en_s = 1'b0;

        // Clear first so that an error event below still sets the flag.
        if (bus.Err_Clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
            unf_d = unf_q;
        end

        if (bus.Ld_Rtn_Addr) begin
            // RETURN outranks a simultaneous branch/call: no push, target ignored.
            if (depth_q != ZERO_DEPTH) begin
                pc_d    = stack_mem_q[ptr_q];
                ptr_d   = ptr_q - PTR_W'(1);
                depth_d = depth_q - DEPTH_W'(1);
            end else begin
                pc_d  = pc_inc_s;
                unf_d = 1'b1;
            end
        end else if (bus.Ld_Brnch_Addr) begin
            pc_d = bus.Brnch_Addr;
            if (bus.Call_Instrn) begin
                if (depth_q == FULL_DEPTH) begin
                    ovf_d = 1'b1;
`ifdef PC_STACK_OVF_WRAP_EN
                    // Advancing past the newest slot lands on the oldest one.
                    ptr_d   = ptr_q + PTR_W'(1);
                    wr_en_s = 1'b1;
`else
                    ptr_d   = ptr_q;
                    wr_en_s = 1'b0;
`endif
                end else begin
                    ptr_d   = ptr_q + PTR_W'(1);
                    depth_d = depth_q + DEPTH_W'(1);
                    wr_en_s = 1'b1;
                end
            end else begin
                wr_en_s = 1'b0;
            end
        end else if (bus.Incrmnt_PC) begin
            pc_d = pc_inc_s;
        end else begin
            pc_d = pc_q;
        end

        // Status flags are registered versions of the next depth.
        empty_d = (depth_d == ZERO_DEPTH);
        full_d  = (depth_d == FULL_DEPTH);
    end

    // PC, stack pointer, depth and status flags with asynchronous reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q    <= RST_PC;
            ptr_q   <= {PTR_W{1'b0}};
            depth_q <= ZERO_DEPTH;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; contents are meaningless until written.
    always_ff @(posedge Clk) begin
        if (wr_en_s) begin
            stack_mem_q[ptr_d] <= pc_inc_s;
        end
    end

    assign bus.PC          = pc_q;
    assign bus.Stack_Empty = empty_q;
    assign bus.Stack_Full  = full_q;
    assign bus.Stack_Ovf   = ovf_q;
    assign bus.Stack_Unf   = unf_q;
endmodule

// File: tb/tb_prgrm_cnt_stack.sv
// Testbench for prgrm_cnt_stack (ADDR_W=8, STACK_DEPTH=8, RESET_ADDR=0).
// Honours PC_STACK_OVF_WRAP_EN the same way the design does.
module tb_prgrm_cnt_stack;
    logic Clk;
    logic Reset_n;

    prgrm_cnt_stack_if #(.ADDR_W(8)) bus ();

    prgrm_cnt_stack #(.ADDR_W(8), .STACK_DEPTH(8), .RESET_ADDR(0)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic       rtn;
        logic       br;
        logic       call;
        logic       inc;
        logic       clr;
        logic [7:0] addr;
    } step_t;

    typedef struct packed {
        logic [7:0] pc;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
    } obs_t;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a plain queue used as a LIFO, newest entry at the back.
    logic [7:0] m_pc;
    logic [7:0] m_stk [$];
    logic       m_ovf;
    logic       m_unf;
    obs_t       exp_q [$];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic obs_t sample();
        obs_t o;
        o.pc    = bus.PC;
        o.empty = bus.Stack_Empty;
        o.full  = bus.Stack_Full;
        o.ovf   = bus.Stack_Ovf;
        o.unf   = bus.Stack_Unf;
        return o;
    endfunction

    task automatic model_reset();
        m_pc  = 8'h00;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Drive one cycle of strobes, predict the result into the scoreboard,
    // then let the edge happen and return 1 time unit after it.
    task automatic drive(input step_t s);
        obs_t e;
        logic [7:0] ret;
        bus.Ld_Rtn_Addr   = s.rtn;
        bus.Ld_Brnch_Addr = s.br;
        bus.Call_Instrn   = s.call;
        bus.Incrmnt_PC    = s.inc;
        bus.Err_Clr       = s.clr;
        bus.Brnch_Addr    = s.addr;
        if (s.clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (s.rtn) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                m_pc  = m_pc + 8'd1;
                m_unf = 1'b1;
            end
        end else if (s.br) begin
            if (s.call) begin
                ret = m_pc + 8'd1;
                if (m_stk.size() == 8) begin
                    m_ovf = 1'b1;
`ifdef PC_STACK_OVF_WRAP_EN
                    void'(m_stk.pop_front());
                    m_stk.push_back(ret);
`endif
                end else begin
                    m_stk.push_back(ret);
                end
            end
            m_pc = s.addr;
        end else if (s.inc) begin
            m_pc = m_pc + 8'd1;
        end
        e.pc    = m_pc;
        e.empty = (m_stk.size() == 0);
        e.full  = (m_stk.size() == 8);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    function automatic step_t mk(input logic rtn, input logic br, input logic call,
                                 input logic inc, input logic clr, input logic [7:0] addr);
        step_t s;
        s.rtn = rtn; s.br = br; s.call = call; s.inc = inc; s.clr = clr; s.addr = addr;
        return s;
    endfunction

    task automatic test_reset();
        obs_t got;
        bus.Ld_Rtn_Addr = 1'b0; bus.Ld_Brnch_Addr = 1'b0; bus.Call_Instrn = 1'b0;
        bus.Incrmnt_PC = 1'b0; bus.Err_Clr = 1'b0; bus.Brnch_Addr = 8'h00;
        Reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        got = sample();
        tests_run++;
        if (got !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset: got %h, expected pc=00 empty=1 full=0 ovf=0 unf=0", got);
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_incr();
        obs_t got, e;
        for (int i = 0; i < 3; i++) begin
            drive(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
            e = exp_q.pop_front();
            got = sample();
            tests_run++;
            if (got !== e || got.pc !== 8'(i + 1)) begin
                tests_failed++;
                $display("FAIL incr step %0d: got pc=%h e=%b, expected pc=%h e=%b", i, got.pc, got.empty, e.pc, e.empty);
            end
        end
    endtask

    task automatic test_call_return();
        step_t st [$];
        obs_t got, e;
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10));
        st.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        foreach (st[i]) begin
            drive(st[i]);
            e = exp_q.pop_front();
            got = sample();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL call_return step %0d: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_overflow();
        step_t st [$];
        obs_t got, e;
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h60));
        for (int i = 1; i <= 9; i++) st.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h60 + 2 * i)));
        for (int i = 0; i < 8; i++) st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        st.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        foreach (st[i]) begin
            drive(st[i]);
            e = exp_q.pop_front();
            got = sample();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL overflow step %0d: got pc=%h e=%b f=%b o=%b u=%b, expected pc=%h e=%b f=%b o=%b u=%b",
                         i, got.pc, got.empty, got.full, got.ovf, got.unf, e.pc, e.empty, e.full, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_underflow();
        step_t st [$];
        obs_t got, e;
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        st.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        foreach (st[i]) begin
            drive(st[i]);
            e = exp_q.pop_front();
            got = sample();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL underflow step %0d: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_priority();
        step_t st [$];
        obs_t got, e;
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h40));
        st.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h54));
        st.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h90));
        st.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hAA));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        foreach (st[i]) begin
            drive(st[i]);
            e = exp_q.pop_front();
            got = sample();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL priority step %0d: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_pc_wrap();
        step_t st [$];
        obs_t got, e;
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF));
        st.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF));
        st.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h30));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        foreach (st[i]) begin
            drive(st[i]);
            e = exp_q.pop_front();
            got = sample();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL pc_wrap step %0d: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, e;
        step_t s;
        for (int i = 0; i < 80; i++) begin
            s.rtn  = ($urandom_range(0, 3) == 0);
            s.br   = ($urandom_range(0, 1) == 0);
            s.call = ($urandom_range(0, 1) == 0);
            s.inc  = ($urandom_range(0, 1) == 0);
            s.clr  = ($urandom_range(0, 7) == 0);
            s.addr = 8'($urandom);
            drive(s);
            e = exp_q.pop_front();
            got = sample();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL back_to_back step %0d: got %h, expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t got, e;
        drive(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h50));
        void'(exp_q.pop_front());
        // Present a call, then pull reset between clock edges.
        bus.Ld_Rtn_Addr = 1'b0; bus.Ld_Brnch_Addr = 1'b1; bus.Call_Instrn = 1'b1;
        bus.Incrmnt_PC = 1'b0; bus.Err_Clr = 1'b0; bus.Brnch_Addr = 8'h77;
        #2;
        Reset_n = 1'b0;
        #1;
        got = sample();
        tests_run++;
        if (got !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL async_reset: got %h, expected pc=00 empty=1 full=0 ovf=0 unf=0", got);
        end
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        drive(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77));
        e = exp_q.pop_front();
        got = sample();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL post_reset_call: got %h, expected %h", got, e);
        end
        drive(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        e = exp_q.pop_front();
        got = sample();
        tests_run++;
        if (got !== e || got.pc !== 8'h01) begin
            tests_failed++;
            $display("FAIL post_reset_return: got %h, expected %h", got, e);
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_call_return();
        test_overflow();
        test_underflow();
        test_priority();
        test_pc_wrap();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
